// File: rtl/sine_4_pkg.sv
// Shared constants, sample type and quarter-wave table for the sine_4 DDS source.
// Table entries are round(32767 * sin(pi/2 * k/64)) for k = 0..64.
package sine_4_pkg;

    localparam int TBL_AW    = 6;
    localparam int TBL_DEPTH = 65;
    localparam int AMP       = 32767;

    typedef logic signed [15:0] sample_t;
    typedef logic        [15:0] mag_t;
    typedef logic     [TBL_AW:0] qaddr_t;

    localparam mag_t QTBL [0:TBL_DEPTH-1] = '{
        16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
        16'd6393,  16'd7179,  16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039, 16'd11793,
        16'd12539, 16'd13279, 16'd14010, 16'd14732, 16'd15446, 16'd16151, 16'd16846, 16'd17530,
        16'd18204, 16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403, 16'd22005, 16'd22594,
        16'd23170, 16'd23731, 16'd24279, 16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
        16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898, 16'd29268, 16'd29621, 16'd29956,
        16'd30273, 16'd30571, 16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785, 16'd31971,
        16'd32137, 16'd32285, 16'd32412, 16'd32521, 16'd32609, 16'd32678, 16'd32728, 16'd32757,
        16'd32767
    };

endpackage

// File: rtl/sine_4_qlut.sv
// Combinational 65-entry quarter-wave ROM: address 0..64 -> unsigned magnitude.
module sine_4_qlut
    import sine_4_pkg::*;
(
    input  qaddr_t addr,
    output mag_t   mag
);

    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        mag = '0;
        if (addr < qaddr_t'(TBL_DEPTH))
            mag = QTBL[addr];
    end

endmodule

// File: rtl/sine_4.sv
// Free-running DDS sine source: phase accumulator, quarter-wave lookup with
// mirroring/negation, and a 2-deep valid pipe that marks sine_out as usable.
module sine_4
    import sine_4_pkg::*;
#(
    parameter int          PHASE_W   = 16,
    parameter int unsigned PHASE_INC = 16384
) (
    input  logic    CLK,
    input  logic    RST_N,
    input  logic    CE,
    output sample_t sine_out,
    output logic    sine_rdy
);

    localparam logic [PHASE_W-1:0] INC = PHASE_W'(PHASE_INC);

    logic [PHASE_W-1:0] acc;
    logic [7:0]         phase;
    logic [1:0]         quad;
    logic [5:0]         idx;
    qaddr_t             lut_addr;
    mag_t               lut_mag;

    mag_t               mag_r;
    logic               neg_r;
    sample_t            sine_r;
    logic [1:0]         vld_r;

    // Odd quadrants walk the quarter table backwards; index 0 there maps to the peak entry.
    assign phase    = acc[PHASE_W-1 -: 8];
    assign quad     = phase[7:6];
    assign idx      = phase[5:0];
    assign lut_addr = quad[0] ? (qaddr_t'(TBL_DEPTH - 1) - {1'b0, idx}) : {1'b0, idx};

    sine_4_qlut u_qlut (
        .addr (lut_addr),
        .mag  (lut_mag)
    );

    // NOTE: non-blocking assignments keep every stage sampling the previous cycle's values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc    <= '0;
            mag_r  <= '0;
            neg_r  <= 1'b0;
            sine_r <= '0;
            vld_r  <= '0;
        end else if (CE) begin
            acc    <= acc + INC;
            mag_r  <= lut_mag;
            neg_r  <= quad[1];
            sine_r <= neg_r ? -sample_t'(mag_r) : sample_t'(mag_r);
            vld_r  <= {vld_r[0], 1'b1};
        end
    end

    assign sine_out = sine_r;
    assign sine_rdy = vld_r[1];

endmodule

// File: tb/tb_sine_4.sv
// Directed self-checking bench for sine_4 at three tuning words (16384, 4096, 1)
// sharing one clock, reset and clock enable.
module tb_sine_4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    logic CE    = 1'b0;

    logic signed [15:0] out_a, out_b, out_c;
    logic               rdy_a, rdy_b, rdy_c;

    int checks   = 0;
    int failures = 0;

    int pat4  [4]  = '{0, 32767, 0, -32767};
    int pat16 [16] = '{0, 12539, 23170, 30273, 32767, 30273, 23170, 12539,
                       0, -12539, -23170, -30273, -32767, -30273, -23170, -12539};
    int obs   [256];
    int min_v, max_v;

    always #5 CLK = ~CLK;

    sine_4 dut_a (.CLK(CLK), .RST_N(RST_N), .CE(CE), .sine_out(out_a), .sine_rdy(rdy_a));
    sine_4 #(.PHASE_INC(4096)) dut_b (.CLK(CLK), .RST_N(RST_N), .CE(CE), .sine_out(out_b), .sine_rdy(rdy_b));
    sine_4 #(.PHASE_INC(1))    dut_c (.CLK(CLK), .RST_N(RST_N), .CE(CE), .sine_out(out_c), .sine_rdy(rdy_c));

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int s_ref(input int p);
        real v;
        v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(p) / 256.0);
        if (v >= 0.0) return int'($floor(v + 0.5));
        else          return -int'($floor(-v + 0.5));
    endfunction

    // Hold reset with CE high for five cycles, checking quiet outputs, then release.
    task automatic hold_reset();
        CE    = 1'b1;
        RST_N = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            check("reset_out", out_a, 0);
            check("reset_rdy", rdy_a, 0);
        end
        RST_N = 1'b1;
    endtask

    initial begin
        // Power-up reset and default tuning
        hold_reset();
        @(negedge CLK);
        check("edge1_rdy", rdy_a, 0);
        check("edge1_out", out_a, 0);
        @(negedge CLK);
        check("edge2_rdy", rdy_a, 1);
        check("edge2_out", out_a, 0);
        for (int k = 1; k < 100; k++) begin
            @(negedge CLK);
            check("inc16384_seq", out_a, pat4[k % 4]);
            check("inc16384_rdy", rdy_a, 1);
        end

        // Asynchronous reset between edges while output is -32767
        #2 RST_N = 1'b0;
        #1;
        check("async_out", out_a, 0);
        check("async_rdy", rdy_a, 0);

        // 16-sample period
        hold_reset();
        @(negedge CLK);
        check("inc4096_edge1_rdy", rdy_b, 0);
        for (int k = 0; k < 32; k++) begin
            @(negedge CLK);
            check("inc4096_seq", out_b, pat16[k % 16]);
            check("inc4096_rdy", rdy_b, 1);
        end

        // Clock-enable gating after the positive peak
        hold_reset();
        @(negedge CLK);
        @(negedge CLK);
        check("ce_first", out_a, 0);
        @(negedge CLK);
        check("ce_peak", out_a, 32767);
        CE = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("ce_hold_out", out_a, 32767);
            check("ce_hold_rdy", rdy_a, 1);
        end
        CE = 1'b1;
        @(negedge CLK);
        check("ce_resume0", out_a, 0);
        @(negedge CLK);
        check("ce_resume1", out_a, -32767);

        // Mid-run reset pulse after seven outputs
        hold_reset();
        @(negedge CLK);
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            check("mid_seq", out_a, pat4[k % 4]);
        end
        #2 RST_N = 1'b0;
        #1;
        check("mid_async_out", out_a, 0);
        check("mid_async_rdy", rdy_a, 0);
        @(negedge CLK);
        check("mid_hold_out", out_a, 0);
        check("mid_hold_rdy", rdy_a, 0);
        RST_N = 1'b1;
        @(negedge CLK);
        check("mid_edge1_rdy", rdy_a, 0);
        @(negedge CLK);
        check("mid_edge2_rdy", rdy_a, 1);
        check("mid_edge2_out", out_a, 0);
        @(negedge CLK);
        check("mid_edge3_out", out_a, 32767);

        // Full accumulator sweep with wrap at increment 1
        hold_reset();
        @(negedge CLK);
        min_v = 0;
        max_v = 0;
        for (int n = 0; n < 65546; n++) begin
            @(negedge CLK);
            check("wrap_seq", out_c, s_ref((n >> 8) & 255));
            if (out_c < min_v) min_v = out_c;
            if (out_c > max_v) max_v = out_c;
            if (n < 65536 && (n % 256) == 0) obs[n >> 8] = out_c;
        end
        check("wrap_rdy", rdy_c, 1);
        check("range_max", max_v, 32767);
        check("range_min", min_v, -32767);
        for (int p = 0; p < 128; p++)
            check("symmetry", obs[p + 128], -obs[p]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
